// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, FSM encoding and small helpers.
// The traffic writer builds flits from the same flit_t, so the field positions live only here.
package noc_pkg;

    localparam int FLIT_W_DEF = 16;
    localparam int SEQ_W      = 11;
    localparam int ID_W       = 2;
    localparam int NUM_SRC    = 4;

    // Packed MSB-first: seq [15:5], src [4:3], dest [2:1], valid [0].
    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [ID_W-1:0]  src;
        logic [ID_W-1:0]  dest;
        logic             valid;
    } flit_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } rd_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/noc_seq_tracker.sv
// Per-source sequence tracker: remembers the next expected seq number and
// flags an out-of-order flit in the same cycle it is presented.
module noc_seq_tracker
    import noc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             hit,
    input  logic [SEQ_W-1:0] seq,
    output logic             err
);

    logic             synced;
    logic [SEQ_W-1:0] expected;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            synced   <= 1'b0;
            expected <= '0;
        end else if (hit) begin
            // Both in-order and out-of-order flits resync to seq+1; 11-bit add wraps mod 2048.
            synced   <= 1'b1;
            expected <= seq + SEQ_W'(1);
        end
    end

    // An unsynced source takes its first flit as the reference, never an error.
    assign err = hit && synced && (seq != expected);

endmodule

// File: rtl/noc_reader.sv
// NoC sink: accepts flits addressed through a router port, counts traffic and
// destination/sequence errors, and reports DONE after a run of idle cycles.
module noc_reader
    import noc_pkg::*;
#(
    parameter int FLIT_W       = FLIT_W_DEF,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLIT_W-1:0] data_in,
    input  logic [1:0]        my_id,
    input  logic              enable,
    output logic [15:0]       rx_count,
    output logic [7:0]        err_dest,
    output logic [7:0]        err_seq,
    output logic [1:0]        last_src,
    output logic [10:0]       last_seq,
    output logic              seq_err,
    output logic              done
);

    localparam int IDLE_CW = $clog2(IDLE_TIMEOUT + 1);

    flit_t              flit;
    logic               accept;
    logic [NUM_SRC-1:0] trk_err;
    logic               any_err;

    assign flit    = flit_t'(data_in[FLIT_W_DEF-1:0]);
    assign accept  = enable && flit.valid;
    assign any_err = |trk_err;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_trk
        noc_seq_tracker u_trk (
            .clk   (clk),
            .reset (reset),
            .hit   (accept && (flit.src == ID_W'(i))),
            .seq   (flit.seq),
            .err   (trk_err[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_count <= '0;
            err_dest <= '0;
            err_seq  <= '0;
            last_src <= '0;
            last_seq <= '0;
            seq_err  <= 1'b0;
        end else begin
            seq_err <= accept && any_err;
            if (accept) begin
                rx_count <= rx_count + 16'd1;
                last_src <= flit.src;
                last_seq <= flit.seq;
                if (flit.dest != my_id)
                    err_dest <= sat_inc8(err_dest);
                if (any_err)
                    err_seq <= sat_inc8(err_seq);
            end
        end
    end

    rd_state_e          state_q;
    rd_state_e          state_d;
    logic [IDLE_CW-1:0] idle_cnt;

    // Counts consecutive no-flit cycles (enable=0 included) while ACTIVE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idle_cnt <= '0;
        else if (accept)
            idle_cnt <= '0;
        else if (state_q == ST_ACTIVE && idle_cnt != IDLE_CW'(IDLE_TIMEOUT))
            idle_cnt <= idle_cnt + IDLE_CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_ACTIVE;
            // Enter DONE on the same edge the idle counter reaches IDLE_TIMEOUT.
            ST_ACTIVE: if (!accept && idle_cnt == IDLE_CW'(IDLE_TIMEOUT - 1)) state_d = ST_DONE;
            ST_DONE:   if (accept) state_d = ST_ACTIVE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        done = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_noc_reader.sv
// Self-checking bench for noc_reader: vector table, directed corner sequences,
// and random traffic against a behavioural model.
module tb_noc_reader;

    localparam int IDLE_TO = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data_in = '0;
    logic [1:0]  my_id = 2'd2;
    logic        enable = 1'b0;
    logic [15:0] rx_count;
    logic [7:0]  err_dest;
    logic [7:0]  err_seq;
    logic [1:0]  last_src;
    logic [10:0] last_seq;
    logic        seq_err;
    logic        done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    noc_reader #(.FLIT_W(16), .IDLE_TIMEOUT(IDLE_TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .my_id    (my_id),
        .enable   (enable),
        .rx_count (rx_count),
        .err_dest (err_dest),
        .err_seq  (err_seq),
        .last_src (last_src),
        .last_seq (last_seq),
        .seq_err  (seq_err),
        .done     (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural model: plain counters, per-source arrays, and the length of
    // the current no-flit run since the first accepted flit.
    int m_rx, m_ed, m_es, m_lsrc, m_lseq, m_run;
    bit m_pulse, m_seen;
    bit m_syn[4];
    int m_exp[4];

    function automatic void model_reset();
        m_rx = 0; m_ed = 0; m_es = 0; m_lsrc = 0; m_lseq = 0; m_run = 0;
        m_pulse = 0; m_seen = 0;
        for (int s = 0; s < 4; s++) begin
            m_syn[s] = 0;
            m_exp[s] = 0;
        end
    endfunction

    function automatic void model_step(input bit en, input bit vld, input int src,
                                       input int dest, input int seq);
        bit bad;
        if (en && vld) begin
            m_rx = (m_rx + 1) % 65536;
            if (dest != int'(my_id) && m_ed < 255) m_ed++;
            bad = m_syn[src] && (seq != m_exp[src]);
            if (bad && m_es < 255) m_es++;
            m_pulse = bad;
            m_syn[src] = 1;
            m_exp[src] = (seq + 1) % 2048;
            m_lsrc = src;
            m_lseq = seq;
            m_seen = 1;
            m_run = 0;
        end else begin
            m_pulse = 0;
            if (m_seen) m_run++;
        end
    endfunction

    task automatic step(input logic en, input logic vld, input logic [1:0] src,
                        input logic [1:0] dest, input logic [10:0] seq);
        enable  = en;
        data_in = {seq, src, dest, vld};
        @(posedge clk);
        #1;
        model_step(en, vld, int'(src), int'(dest), int'(seq));
        check("rx_count", rx_count, m_rx);
        check("err_dest", err_dest, m_ed);
        check("err_seq",  err_seq,  m_es);
        check("last_src", last_src, m_lsrc);
        check("last_seq", last_seq, m_lseq);
        check("seq_err",  seq_err,  m_pulse);
        check("done",     done,     (m_seen && m_run >= IDLE_TO) ? 1 : 0);
    endtask

    task automatic do_reset();
        enable  = 1'b0;
        data_in = '0;
        reset   = 1'b1;
        #2;
        check("rst_rx_count", rx_count, 0);
        check("rst_err_dest", err_dest, 0);
        check("rst_err_seq",  err_seq,  0);
        check("rst_last_src", last_src, 0);
        check("rst_last_seq", last_seq, 0);
        check("rst_seq_err",  seq_err,  0);
        check("rst_done",     done,     0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic        en;
        logic        vld;
        logic [1:0]  src;
        logic [1:0]  dest;
        logic [10:0] seq;
        logic [15:0] x_rx;
        logic [7:0]  x_ed;
        logic [7:0]  x_es;
        logic        x_se;
        logic [1:0]  x_lsrc;
        logic [10:0] x_lseq;
    } vec_t;

    function automatic vec_t mk(input logic en, input logic vld, input logic [1:0] src,
                                input logic [1:0] dest, input logic [10:0] seq,
                                input logic [15:0] x_rx, input logic [7:0] x_ed,
                                input logic [7:0] x_es, input logic x_se,
                                input logic [1:0] x_lsrc, input logic [10:0] x_lseq);
        vec_t v;
        v.en = en; v.vld = vld; v.src = src; v.dest = dest; v.seq = seq;
        v.x_rx = x_rx; v.x_ed = x_ed; v.x_es = x_es; v.x_se = x_se;
        v.x_lsrc = x_lsrc; v.x_lseq = x_lseq;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        model_reset();
        my_id = 2'd2;

        // Vector table, my_id=2: in-order stream, ignored cycles, a seq gap, a wrap.
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(1, 1, 0, 2, 11'(i), 16'(i + 1), 0, 0, 0, 0, 11'(i)));
        vecs.push_back(mk(1, 0, 3, 1, 11'h7FF, 10, 0, 0, 0, 0, 9));
        vecs.push_back(mk(0, 1, 1, 2, 100,     10, 0, 0, 0, 0, 9));
        vecs.push_back(mk(1, 1, 1, 2, 5,       11, 0, 0, 0, 1, 5));
        vecs.push_back(mk(1, 1, 1, 2, 6,       12, 0, 0, 0, 1, 6));
        vecs.push_back(mk(1, 1, 1, 2, 8,       13, 0, 1, 1, 1, 8));
        vecs.push_back(mk(1, 1, 1, 2, 9,       14, 0, 1, 0, 1, 9));
        vecs.push_back(mk(1, 1, 3, 2, 2046,    15, 0, 1, 0, 3, 2046));
        vecs.push_back(mk(1, 1, 3, 2, 2047,    16, 0, 1, 0, 3, 2047));
        vecs.push_back(mk(1, 1, 3, 2, 0,       17, 0, 1, 0, 3, 0));
        vecs.push_back(mk(1, 1, 3, 2, 1,       18, 0, 1, 0, 3, 1));
        vecs.push_back(mk(1, 1, 0, 0, 10,      19, 1, 1, 0, 0, 10));

        do_reset();
        foreach (vecs[k]) begin
            step(vecs[k].en, vecs[k].vld, vecs[k].src, vecs[k].dest, vecs[k].seq);
            check("vec_rx",   rx_count, vecs[k].x_rx);
            check("vec_ed",   err_dest, vecs[k].x_ed);
            check("vec_es",   err_seq,  vecs[k].x_es);
            check("vec_se",   seq_err,  vecs[k].x_se);
            check("vec_lsrc", last_src, vecs[k].x_lsrc);
            check("vec_lseq", last_seq, vecs[k].x_lseq);
        end

        // 300 misaddressed flits: err_dest saturates, every flit still counted.
        do_reset();
        for (int i = 0; i < 300; i++)
            step(1, 1, 2, 1, 11'(i));
        check("sat_err_dest", err_dest, 255);
        check("sat_rx_count", rx_count, 300);
        check("sat_err_seq",  err_seq,  0);

        // Idle timeout: done rises on exactly the 64th no-flit cycle.
        do_reset();
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 2, 11'(i));
        for (int k = 1; k <= IDLE_TO; k++) begin
            step((k % 3) != 0, 0, 0, 0, 0);
            check("idle_done", done, (k == IDLE_TO) ? 1 : 0);
        end
        step(1, 1, 0, 2, 3);
        check("wake_done", done, 0);
        check("wake_err_seq", err_seq, 0);

        // Reset mid-stream, then a post-reset flit resyncs without error.
        do_reset();
        for (int i = 0; i < 4; i++)
            step(1, 1, 0, 2, 11'(i));
        do_reset();
        step(1, 1, 0, 2, 10);
        check("post_rst_rx", rx_count, 1);
        check("post_rst_es", err_seq, 0);
        check("post_rst_se", seq_err, 0);

        // Random traffic against the model, with idle bursts and one mid-run reset.
        do_reset();
        my_id = 2'($urandom_range(0, 3));
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) begin
                do_reset();
                my_id = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 99) < 3) begin
                int len;
                len = $urandom_range(60, 70);
                for (int j = 0; j < len; j++)
                    step(1'($urandom_range(0, 1)), 0, 2'($urandom), 2'($urandom), 11'($urandom));
            end else begin
                logic [1:0]  src;
                logic [10:0] seq;
                src = 2'($urandom_range(0, 3));
                if (m_syn[src] && $urandom_range(0, 3) != 0)
                    seq = 11'(m_exp[src]);
                else
                    seq = 11'($urandom);
                step(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) != 0),
                     src, 2'($urandom_range(0, 3)), seq);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_reader.md
NOC_READER -- requirements
Module: noc_reader

Interface
REQ-001 SHALL have parameter FLIT_W, default 16, flit width in bits.
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 64, consecutive no-flit cycles after first flit before entering DONE.
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port data_in  input  FLIT_W  flit from router output port: [15:5] seq, [4:3] src id, [2:1] dest id, [0] valid.
REQ-006 SHALL have port my_id  input  2  this node's id, quasi-static.
REQ-007 SHALL have port enable  input  1  1 = accept flits, 0 = ignore data_in.
REQ-008 SHALL have port rx_count  output  16  total valid flits accepted.
REQ-009 SHALL have port err_dest  output  8  count of flits whose dest != my_id.
REQ-010 SHALL have port err_seq  output  8  count of out-of-order flits.
REQ-011 SHALL have port last_src  output  2  src of most recent accepted flit.
REQ-012 SHALL have port last_seq  output  11  seq of most recent accepted flit.
REQ-013 SHALL have port seq_err  output  1  one-cycle pulse on sequence error.
REQ-014 SHALL have port done  output  1  high while FSM is in DONE.

Function
REQ-015 SHALL accept a flit in a cycle where data_in[0]=1 and enable=1; accepted flits update all outputs on the next rising edge (1-cycle latency, registered).
REQ-016 SHALL increment rx_count by 1 per accepted flit, wrapping 65535->0.
REQ-017 SHALL increment err_dest when dest != my_id, saturating at 255; the flit is still counted and sequence-checked.
REQ-018 SHALL keep per-source (4) state: synced bit, expected seq (11 bits).
REQ-019 SHALL, on the first flit from an unsynced source, set synced=1, expected=seq+1, no error.
REQ-020 SHALL, on a synced source with seq==expected, set expected=seq+1; with seq!=expected, increment err_seq (saturating at 255), pulse seq_err, resync expected=seq+1.
REQ-021 SHALL wrap expected seq modulo 2048 (2047 followed by 0 is in order).
REQ-022 SHALL implement FSM IDLE -> ACTIVE on first accepted flit; ACTIVE -> DONE when idle counter reaches IDLE_TIMEOUT; DONE -> ACTIVE on any accepted flit.
REQ-023 SHALL clear the idle counter on each accepted flit and increment it (saturating) otherwise in ACTIVE.
REQ-024 SHALL treat enable=0 cycles as no-flit cycles (idle counter advances, no counters change).
REQ-025 SHALL leave outputs unchanged when data_in[0]=0 regardless of other bits.

Reset
REQ-026 SHALL, on reset, set rx_count=0, err_dest=0, err_seq=0, last_src=0, last_seq=0, seq_err=0, done=0, FSM=IDLE, idle counter=0, all synced=0, all expected=0.
REQ-027 SHALL honour reset asserted mid-stream immediately; the first post-reset flit from each source re-syncs with no error.

Structure
REQ-028 SHALL take flit field positions, FLIT_W and FSM state encoding from shared package noc_pkg, also used by the traffic writer.
REQ-029 SHALL instantiate one sub-module noc_seq_tracker per source (4 instances) holding synced/expected and producing an error strobe.

Verification
REQ-030 SHALL cover: my_id=2, src 0 sends seq 0..9 dest 2 back-to-back -> rx_count=10, err_dest=0, err_seq=0, last_seq=9.
REQ-031 SHALL cover: src 1 sends seq 5,6,8 dest=my_id -> err_seq=1, seq_err pulses once the cycle after seq 8, next expected 9.
REQ-032 SHALL cover: src 3 sends seq 2046,2047,0,1 -> err_seq=0 (wrap-around).
REQ-033 SHALL cover: 300 flits with dest != my_id -> err_dest=255 (saturated), rx_count=300.
REQ-034 SHALL cover: 3 flits then 64 valid=0 cycles -> done=1 exactly on cycle 64 after last flit; new flit -> done=0 next cycle.
REQ-035 SHALL cover: reset asserted after src 0 seq 0..3, then seq 10 -> all counters 0 then rx_count=1, err_seq=0.
